serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder that feeds operands one bit per clock into a single full_adder instance and accumulates the sum. It is the sequential stage directly upstream of the full_adder: it registers the operands, presents LSB-first bit pairs plus a stored carry, and collects output_S/output_C back into a result register. It trades a ripple chain of WIDTH adders for one adder, a shift datapath and a small controller.

---
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder is reused LSB-first across WIDTH
// clock edges, with a small IDLE/RUN/DONE controller around the shift datapath.

module full_adder (
  input  logic input_A,
  input  logic input_B,
  input  logic input_C,
  output logic output_S,
  output logic output_C
);
  assign output_S = input_A ^ input_B ^ input_C;
  assign output_C = (input_A & input_B) | (input_C & (input_A ^ input_B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic             input_C,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] output_S,
  output logic             output_C
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            fa_s, fa_c;
  logic            load, shift, last;

  full_adder u_fa (
    .input_A (a_sh[0]),
    .input_B (b_sh[0]),
    .input_C (carry),
    .output_S(fa_s),
    .output_C(fa_c)
  );

  // The sum bit enters at the MSB so that after WIDTH shifts s_sh is LSB-aligned.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_next = fa_s;
    end else begin : g_wn
      assign s_next = {fa_s, s_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        shift = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        load      = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      output_S <= '0;
      output_C <= 1'b0;
    end else if (load) begin
      a_sh  <= input_A;
      b_sh  <= input_B;
      carry <= input_C;
      cnt   <= '0;
    end else if (shift) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_next;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        output_S <= s_next;
        output_C <= fa_c;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, input_C;
  logic [7:0] input_A, input_B;
  logic       busy, done, output_C;
  logic [7:0] output_S;

  logic       start1, c1;
  logic [0:0] a1, b1;
  logic       busy1, done1, oc1;
  logic [0:0] os1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .input_A(input_A), .input_B(input_B), .input_C(input_C),
    .busy(busy), .done(done), .output_S(output_S), .output_C(output_C)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .input_A(a1), .input_B(b1), .input_C(c1),
    .busy(busy1), .done(done1), .output_S(os1), .output_C(oc1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one WIDTH=8 operation and returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec);
    int lat, nbusy;
    bit seen;
    @(negedge clk);
    input_A = a; input_B = b; input_C = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; nbusy = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      nbusy += int'(busy);
      @(negedge clk);
    end
    check({tag, " done_seen"}, seen, 1);
    check({tag, " latency"}, lat, 8);
    check({tag, " busy_cycles"}, nbusy, 8);
    check({tag, " busy_with_done"}, busy, 0);
    check({tag, " sum"}, output_S, es);
    check({tag, " carry"}, output_C, ec);
  endtask

  task automatic run_op1(input string tag, input logic a, input logic b,
                         input logic c, input logic es, input logic ec);
    int lat;
    bit seen;
    @(negedge clk);
    a1 = a; b1 = b; c1 = c; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done1) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, " done_seen"}, seen, 1);
    check({tag, " latency"}, lat, 1);
    check({tag, " sum"}, os1, es);
    check({tag, " carry"}, oc1, ec);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  npulse, lat;
    bit  hold_bad, seen;
    logic [7:0] res;

    rst_n = 1'b0; start = 1'b0; input_A = '0; input_B = '0; input_C = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", output_S, 8'h00);
    check("reset carry", output_C, 0);
    check("reset w1 busy/done", {busy1, done1, os1, oc1}, 4'b0000);
    rst_n = 1'b1;

    // Basic sums and carry boundaries
    run_op("5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    @(negedge clk);
    check("5a+3c done_pulse_width", done, 0);
    run_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    run_op("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    run_op("7f+01+1", 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0);
    run_op("c3+3c", 8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0);
    run_op("aa+55+1", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);

    // start held and operands scrambled during RUN: no restart, one done
    @(negedge clk);
    input_A = 8'h12; input_B = 8'h34; input_C = 1'b0; start = 1'b1;
    npulse = 0; res = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) begin
        npulse++;
        res   = output_S;
        start = 1'b0;
      end else if (start) begin
        input_A = 8'($urandom);
        input_B = 8'($urandom);
      end
    end
    start = 1'b0;
    check("hold_start done_pulses", npulse, 1);
    check("hold_start sum", res, 8'h46);

    // Back-to-back: start in the DONE cycle
    run_op("b2b first", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    input_A = 8'h01; input_B = 8'h01; input_C = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy_no_gap", busy, 1);
    check("b2b done_low", done, 0);
    hold_bad = 1'b0; seen = 1'b0; lat = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (output_S !== 8'h96 || output_C !== 1'b0) hold_bad = 1'b1;
      @(negedge clk);
    end
    check("b2b hold", hold_bad, 0);
    check("b2b latency", lat, 8);
    check("b2b done_seen", seen, 1);
    check("b2b sum", output_S, 8'h02);
    check("b2b carry", output_C, 0);

    // Reset in the 4th RUN cycle
    @(negedge clk);
    input_A = 8'hAA; input_B = 8'h55; input_C = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort running", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", output_S, 8'h00);
    check("abort carry", output_C, 0);
    npulse = 0;
    for (int k = 0; k < 12; k++) begin
      npulse += int'(done) + int'(busy);
      @(negedge clk);
    end
    check("abort stays_idle", npulse, 0);
    run_op("after_abort", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // WIDTH=1 instance: RUN lasts exactly one edge
    run_op1("w1 1+1+1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_op1("w1 1+0+0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op1("w1 0+1+1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    run_op1("w1 0+0+0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
